// File: rtl/m_lsu.sv
// m_lsu: single-outstanding load/store unit between the M stage and a req/ack memory port
// Ports: clk, reset (sync, active-low); M_Valid/M_MemOp/M_Addr/M_WData from the M stage;
// M_LoadData (registered load result), M_Stall, M_AddrErr (comb), M_BusErr (sticky);
// mem_req/mem_we/mem_addr/mem_byteen/mem_wdata out, mem_ack/mem_rdata in.
module m_lsu #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_Valid,
  input  logic [3:0]  M_MemOp,
  input  logic [31:0] M_Addr,
  input  logic [31:0] M_WData,
  output logic [31:0] M_LoadData,
  output logic        M_Stall,
  output logic        M_AddrErr,
  output logic        M_BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam logic [3:0] LW = 4'd1, LH = 4'd2, LHU = 4'd3, LB = 4'd4, LBU = 4'd5;
  localparam logic [3:0] SW = 4'd6, SH = 4'd7, SB = 4'd8;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_op, r_be, w_be;
  logic [31:0] r_addr, r_wdata, w_wd, w_sh, w_ext;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [4:0]  r_cnt;
  logic        w_nop, w_align, w_accept, w_load, w_tmo;
  always_comb begin
    w_nop    = M_MemOp == 4'd0 || M_MemOp > SB;
    w_align  = (M_MemOp == LW || M_MemOp == SW) ? M_Addr[1:0] == 2'b00 :
               (M_MemOp == LH || M_MemOp == LHU || M_MemOp == SH) ? !M_Addr[0] : 1'b1;
    w_accept = r_state == IDLE && M_Valid && !w_nop && w_align;
    w_be     = M_MemOp == SH ? (M_Addr[1] ? 4'b1100 : 4'b0011) :
               M_MemOp == SB ? 4'b0001 << M_Addr[1:0] : 4'b1111;
    w_wd     = M_MemOp == SH ? {2{M_WData[15:0]}} :
               M_MemOp == SB ? {4{M_WData[7:0]}} : M_WData;
    w_load   = r_op >= LW && r_op <= LBU;
    w_sh     = mem_rdata >> {r_addr[1:0], 3'b000};
    w_byte   = w_sh[7:0];
    w_half   = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_ext    = r_op == LH  ? {{16{w_half[15]}}, w_half} :
               r_op == LHU ? {16'd0, w_half} :
               r_op == LB  ? {{24{w_byte[7]}}, w_byte} :
               r_op == LBU ? {24'd0, w_byte} : mem_rdata;
    w_tmo    = r_cnt == 5'(ACK_TIMEOUT - 1);
    w_next   = r_state == IDLE ? (w_accept ? REQ : IDLE) :
               r_state == REQ  ? ((mem_ack || w_tmo) ? DONE : REQ) : IDLE;
    M_AddrErr  = r_state == IDLE && M_Valid && !w_nop && !w_align;
    M_Stall    = w_accept || r_state == REQ;
    mem_req    = r_state == REQ;
    mem_we     = r_state == REQ && r_op >= SW;
    mem_addr   = {r_addr[31:2], 2'b00};
    mem_byteen = r_be;
    mem_wdata  = r_wdata;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_cnt      <= '0;
      M_LoadData <= '0;
      M_BusErr   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op     <= M_MemOp;
        r_addr   <= M_Addr;
        r_wdata  <= w_wd;
        r_be     <= w_be;
        r_cnt    <= '0;
        M_BusErr <= 1'b0;
      end
      if (r_state == REQ) begin
        if (mem_ack) begin
          if (w_load) M_LoadData <= w_ext;
        end else if (w_tmo) begin
          M_BusErr <= 1'b1;
          if (w_load) M_LoadData <= '0;
        end else begin
          r_cnt <= r_cnt + 5'd1;
        end
      end
    end
  end
endmodule
